stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit stream multiplexer. It is the successor to the 2:1 combinational mux.
- Each input channel carries a valid/ready handshake. The output is a single registered valid/ready stream.
- Two selection modes:
  - fixed: an external select chooses the channel.
  - round-robin: fair arbitration among channels that are requesting.
- Sits between multiple producers and a single consumer, e.g. when merging sensor or UART byte streams onto one bus.

---
 rtl/stream_mux_rr.sv | 175 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel, W-bit valid/ready stream multiplexer with one registered output stage and
// fixed-select or round-robin arbitration. Define STREAM_MUX_PKT_LOCK_EN to hold a grant for a whole packet.
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int NSEL = 1 << SW;

    if (N < 2 || NSEL < N) begin : g_bad_params
        $error("stream_mux_rr: requires N >= 2 and 2**SW >= N");
    end

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic            ld;
    logic [NSEL-1:0] valid_ext;
    logic [SW:0]     rr_sum;
    logic [SW-1:0]   rr_grant;
    logic            rr_gvalid;
    logic [SW-1:0]   grant;
    logic            gvalid;
    logic            accept;
    logic [W-1:0]    grant_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            lock_q, lock_d;
    logic [SW-1:0]   lock_ch_q, lock_ch_d;
    logic            grant_last;
`else
    logic            unused_last;
    assign unused_last = ^in_last;
`endif

    assign ld = !out_valid_q || out_ready;

    // Zero-padded to 2**SW entries so an out-of-range sel simply reads as "not valid".
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
        valid_ext          = '0;
        valid_ext[N-1:0]   = in_valid;
    end

    // Scan ptr, ptr+1, ..., wrapping at N; the first requesting channel wins.
    always_comb begin
        rr_sum    = '0;
        rr_grant  = '0;
        rr_gvalid = 1'b0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (rr_sum >= (SW+1)'(N)) begin
                rr_sum = rr_sum - (SW+1)'(N);
            end
            if (!rr_gvalid && valid_ext[rr_sum[SW-1:0]]) begin
                rr_grant  = rr_sum[SW-1:0];
                rr_gvalid = 1'b1;
            end
        end
    end

    always_comb begin
        grant  = sel;
        gvalid = valid_ext[sel];
        if (mode) begin
            grant  = rr_grant;
            gvalid = rr_gvalid;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            grant  = lock_ch_q;
            gvalid = valid_ext[lock_ch_q];
        end
`endif
    end

    // Ready is held low during reset even though the output register reads empty.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && ld && gvalid && (grant == SW'(i));
        end
    end

    assign accept = |(in_valid & in_ready);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (ld) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = grant_data;
                out_ch_d   = grant;
                if (mode) begin
                    ptr_d = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // A non-last beat opens a packet on its channel; the last beat closes it.
    always_comb begin
        grant_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                grant_last = in_last[i];
            end
        end
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            lock_d    = !grant_last;
            lock_ch_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    stream_mux_rr #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: output register contents, rotation pointer and packet lock.
    int       m_ptr;
    bit       m_lock;
    int       m_lock_ch;
    bit       m_ov;
    logic [W-1:0] m_od;
    int       m_och;

    function automatic void model_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (m_lock) begin
            g  = m_lock_ch;
            gv = in_valid[g];
            return;
        end
`endif
        if (!mode) begin
            g  = int'(sel);
            gv = (g < N) && in_valid[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (in_valid[c]) begin
                    g  = c;
                    gv = 1'b1;
                    break;
                end
            end
        end
    endfunction

    // Compare process: inputs are settled by negedge+3 and hold until the next posedge.
    initial begin
        int          g;
        bit          gv;
        bit          ld;
        logic [N-1:0] exp_rdy;
        m_ptr = 0; m_lock = 0; m_lock_ch = 0; m_ov = 0; m_od = '0; m_och = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                check("rst_in_ready", 32'(in_ready), 32'(0));
                check("rst_out_valid", 32'(out_valid), 32'(0));
                check("rst_out_data", 32'(out_data), 32'(0));
                check("rst_out_ch", 32'(out_ch), 32'(0));
                m_ptr = 0; m_lock = 0; m_lock_ch = 0; m_ov = 0; m_od = '0; m_och = 0;
            end else begin
                model_grant(g, gv);
                ld      = !m_ov || out_ready;
                exp_rdy = (ld && gv) ? N'(1 << g) : '0;
                check("in_ready", 32'(in_ready), 32'(exp_rdy));
                check("out_valid", 32'(out_valid), 32'(m_ov));
                if (m_ov) begin
                    check("out_data", 32'(out_data), 32'(m_od));
                    check("out_ch", 32'(out_ch), 32'(m_och));
                end
                if (ld) begin
                    if (gv) begin
                        m_od  = in_data[g*W +: W];
                        m_och = g;
                        m_ov  = 1'b1;
                        if (mode) m_ptr = (g + 1) % N;
`ifdef STREAM_MUX_PKT_LOCK_EN
                        if (!in_last[g]) begin
                            m_lock    = 1'b1;
                            m_lock_ch = g;
                        end else begin
                            m_lock = 1'b0;
                        end
`endif
                    end else begin
                        m_ov = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] acc;
        int           b1;
        int           c2;
        int           exp_seq[4];

`ifdef STREAM_MUX_PKT_LOCK_EN
        exp_seq = '{1, 1, 1, 2};
`else
        exp_seq = '{1, 2, 1, 2};
`endif

        // Reset with every channel requesting.
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h10 + i);
        repeat (2) mid();
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_out_ch", 32'(out_ch), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(0));
        tick();
        rst_n = 1'b1;
        mid();
        check("first_grant_ch0", 32'(in_ready), 32'b0001);

        // Round-robin fairness: one beat per cycle, rotating 0..3.
        for (int b = 0; b < 8; b++) begin
            tick();
            mid();
            check("rr_out_valid", 32'(out_valid), 32'(1));
            check("rr_out_ch", 32'(out_ch), 32'(b % 4));
            check("rr_out_data", 32'(out_data), 32'(8'h10 + (b % 4)));
        end

        // Backpressure: held beat stays put, nothing is accepted.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            mid();
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_out_ch", 32'(out_ch), 32'(3));
            check("bp_out_data", 32'(out_data), 32'h13);
            check("bp_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        mid();
        check("bp_release_ch", 32'(out_ch), 32'(0));
        check("bp_release_data", 32'(out_data), 32'h10);

        // Sparse requests 4'b1001: 0, then 3 (ptr=1), then 0 (ptr wrapped).
        tick();
        rst_n    = 1'b0;
        in_valid = 4'b1001;
        repeat (2) tick();
        rst_n = 1'b1;
        mid();
        check("sparse_ready0", 32'(in_ready), 32'b0001);
        tick();
        mid();
        check("sparse_ch0", 32'(out_ch), 32'(0));
        check("sparse_ready3", 32'(in_ready), 32'b1000);
        tick();
        mid();
        check("sparse_ch3", 32'(out_ch), 32'(3));
        check("sparse_ready0b", 32'(in_ready), 32'b0001);
        tick();
        mid();
        check("sparse_ch0b", 32'(out_ch), 32'(0));

        // Fixed select of channel 2.
        tick();
        rst_n    = 1'b0;
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0110;
        in_data[2*W +: W] = 8'hA5;
        repeat (2) tick();
        rst_n = 1'b1;
        mid();
        check("fixed_ready", 32'(in_ready), 32'b0100);
        tick();
        mid();
        check("fixed_data", 32'(out_data), 32'hA5);
        check("fixed_ch", 32'(out_ch), 32'(2));

        // Three-beat packet on channel 1 competing with channel 2.
        tick();
        rst_n    = 1'b0;
        mode     = 1'b1;
        in_valid = 4'b0110;
        in_last  = 4'b0100;
        in_data[1*W +: W] = 8'hB0;
        in_data[2*W +: W] = 8'hC0;
        b1 = 0;
        c2 = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            acc = in_valid & in_ready;
            tick();
            check("pkt_out_ch", 32'(out_ch), 32'(exp_seq[c]));
            if (acc[1]) begin
                b1++;
                if (b1 < 3) begin
                    in_data[1*W +: W] = W'(8'hB0 + b1);
                    in_last[1]        = (b1 == 2);
                end else begin
                    in_valid[1] = 1'b0;
                end
            end
            if (acc[2]) begin
                c2++;
                in_data[2*W +: W] = W'(8'hC0 + c2);
            end
        end

        // Randomized traffic; producers hold data until their beat is accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #2;
            acc = in_valid & in_ready;
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        in_valid[i]       = 1'b1;
                        in_data[i*W +: W] = W'($urandom);
                        in_last[i]        = ($urandom_range(0, 2) == 0);
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end
            end
            if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) sel = SW'($urandom_range(0, N-1));
            out_ready = ($urandom_range(0, 3) != 0);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
